// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the Uart8 echo responder slice.
//   BYTE_W      data width of the Uart8 byte link
//   txState_t   transmit FSM states (IDLE/LOAD/START/WAIT)
//   ASCII_*     case constants used by the optional upper-case transform
//   upcase()    maps 8'h61..8'h7A to byte - 8'h20, all other bytes unchanged
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } txState_t;

    localparam logic [BYTE_W-1:0] ASCII_LOWER_A     = 8'h61;
    localparam logic [BYTE_W-1:0] ASCII_LOWER_Z     = 8'h7A;
    localparam logic [BYTE_W-1:0] ASCII_CASE_OFFSET = 8'h20;

    function automatic logic [BYTE_W-1:0] upcase(input logic [BYTE_W-1:0] b);
        if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z)
            return b - ASCII_CASE_OFFSET;
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO, read data registered on pop.
//   clk, reset   rising-edge clock, synchronous active-low reset
//   push, wrData write request; accepted when not full or when popping
//   pop, rdData  read request; rdData updates on the pop edge
//   full, empty  occupancy flags
//   level        occupancy 0..DEPTH (wrPtr - rdPtr, AW+1-bit pointers)
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] wrData,
    input  logic              pop,
    output logic [BYTE_W-1:0] rdData,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wrPtr;
    logic [AW:0]       rdPtr;
    logic              doPush;
    logic              doPop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign empty  = (wrPtr == rdPtr);
    assign level  = wrPtr - rdPtr;
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk) begin
        if (doPush)
            mem[wrPtr[AW-1:0]] <= wrData;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            rdData <= '0;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + 1'b1;
            if (doPop) begin
                rdPtr  <= rdPtr + 1'b1;
                rdData <= mem[rdPtr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: far-end echo partner for one Uart8.
// Queues every good received byte and retransmits it in arrival order.
//   clk, reset   rising-edge clock, synchronous active-low reset
//   en           1 = may start new transmissions; reception always continues
//   rxDone/rxErr/rxByte   Uart8 rx side; rising rxDone marks a new byte
//   txBusy/txDone         Uart8 tx status
//   txStart/txByte        Uart8 tx request and data
//   level        FIFO occupancy 0..DEPTH
//   overflow     sticky: a good byte was dropped on a full FIFO
//   err_count    saturating count of bytes received with rxErr
// Optional macro UART_ECHO_UPCASE_EN: popped lower-case ASCII is sent upper-case.
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              rxDone,
    input  logic              rxErr,
    input  logic [BYTE_W-1:0] rxByte,
    input  logic              txBusy,
    input  logic              txDone,
    output logic              txStart,
    output logic [BYTE_W-1:0] txByte,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic [7:0]        err_count
);

    txState_t          state;
    txState_t          stateNext;
    logic              txStartNext;
    logic              rxDoneQ;
    logic              txDoneQ;
    logic              txBusyQ;
    logic              rxEdge;
    logic              goodPush;
    logic              pop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [BYTE_W-1:0] fifoRdData;

    assign rxEdge   = rxDone && !rxDoneQ;
    assign goodPush = rxEdge && !rxErr;
    assign pop      = (state == LOAD);

    uart_byte_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (goodPush),
        .wrData (rxByte),
        .pop    (pop),
        .rdData (fifoRdData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .level  (level)
    );

    // FIFO keeps raw bytes; the popped byte is transformed on its way out.
`ifdef UART_ECHO_UPCASE_EN
    assign txByte = upcase(fifoRdData);
`else
    assign txByte = fifoRdData;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            txStart   <= 1'b0;
            rxDoneQ   <= 1'b0;
            txDoneQ   <= 1'b0;
            txBusyQ   <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            state   <= stateNext;
            txStart <= txStartNext;
            rxDoneQ <= rxDone;
            txDoneQ <= txDone;
            txBusyQ <= txBusy;
            if (rxEdge && rxErr && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (goodPush && fifoFull && !pop)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        stateNext   = state;
        txStartNext = txStart;
        case (state)
            IDLE: begin
                if (en && !fifoEmpty)
                    stateNext = LOAD;
            end
            LOAD: begin
                txStartNext = 1'b1;
                stateNext   = START;
            end
            START: begin
                if (txBusy) begin
                    txStartNext = 1'b0;
                    stateNext   = WAIT;
                end
            end
            WAIT: begin
                // Either completion indication ends the transfer.
                if ((txDone && !txDoneQ) || (txBusyQ && !txBusy))
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_echo_responder.sv
module tb_uart_echo_responder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxByte;
    logic       respBusy;
    logic       manBusy;
    logic       txBusy;
    logic       txDone;
    logic       txStart;
    logic [7:0] txByte;
    logic [3:0] level;
    logic       overflow;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] expQ[$];
    logic [7:0] txLog[$];
    int         errModel;
    bit         ovModel;
    bit         respOn;

    assign txBusy = respBusy | manBusy;

    always #5 clk = ~clk;

    uart_echo_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .rxDone    (rxDone),
        .rxErr     (rxErr),
        .rxByte    (rxByte),
        .txBusy    (txBusy),
        .txDone    (txDone),
        .txStart   (txStart),
        .txByte    (txByte),
        .level     (level),
        .overflow  (overflow),
        .err_count (err_count)
    );

    function automatic logic [7:0] xform(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A)
            return b - 8'h20;
`endif
        return b;
    endfunction

    // Uart8 transmitter stand-in: accepts a start, goes busy, then signals done.
    initial begin
        logic [7:0] b;
        respBusy = 1'b0;
        txDone   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (respOn && txStart && !txBusy) begin
                b = txByte;
                repeat (2) @(posedge clk);
                #1 respBusy = 1'b1;
                @(posedge clk); #1;
                total++;
                if (txStart !== 1'b0) begin
                    bad++;
                    $display("FAIL txStartDrop: got %b want 0", txStart);
                end
                repeat (3) @(posedge clk);
                #1;
                total++;
                if (txByte !== b) begin
                    bad++;
                    $display("FAIL txByteStable: got %h want %h", txByte, b);
                end
                respBusy = 1'b0;
                txDone   = 1'b1;
                @(posedge clk); #1;
                txDone = 1'b0;
                txLog.push_back(b);
            end
        end
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic pushByte(input logic [7:0] b, input bit e);
        if (e) begin
            if (errModel < 255) errModel++;
        end else if ((expQ.size() - txLog.size()) < DEPTH) begin
            expQ.push_back(b);
        end else begin
            ovModel = 1'b1;
        end
        rxByte = b;
        rxErr  = e;
        rxDone = 1'b1;
        @(posedge clk); #1;
        rxDone = 1'b0;
        rxErr  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        expQ.delete();
        txLog.delete();
        errModel = 0;
        ovModel  = 1'b0;
    endtask

    task automatic waitDrain(input int n, output bit ok);
        for (int c = 0; c < 800; c++) begin
            if (txLog.size() >= n) break;
            @(posedge clk); #1;
        end
        ok = (txLog.size() >= n);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyReset();
        total++; if (txStart !== 1'b0)  begin bad++; $display("FAIL rst_txStart: got %b want 0", txStart); end
        total++; if (txByte !== 8'h00)  begin bad++; $display("FAIL rst_txByte: got %h want 00", txByte); end
        total++; if (level !== 4'd0)    begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rst_err: got %0d want 0", err_count); end
    endtask

    task automatic test_single();
        int lat;
        bit ok;
        applyReset();
        en = 1'b1;
        respOn = 1'b1;
        expQ.push_back(8'h8A);
        rxByte = 8'h8A; rxErr = 1'b0; rxDone = 1'b1;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) rxDone = 1'b0;
            if (txStart) begin lat = c; break; end
        end
        total++; if (lat != 3) begin bad++; $display("FAIL single_latency: got %0d want 3", lat); end
        total++; if (txByte !== 8'h8A) begin bad++; $display("FAIL single_byte: got %h want 8a", txByte); end
        waitDrain(1, ok);
        total++; if (!ok || txLog[0] !== 8'h8A) begin bad++; $display("FAIL single_echo: got %0d bytes want 8a", txLog.size()); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL single_level: got %0d want 0", level); end
    endtask

    task automatic test_burst();
        bit ok;
        applyReset();
        en = 1'b0;
        for (int i = 1; i <= 8; i++) pushByte(8'(i), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++; if (level !== 4'd8) begin bad++; $display("FAIL burst_level: got %0d want 8", level); end
        total++; if (txStart !== 1'b0) begin bad++; $display("FAIL burst_hold: got %b want 0", txStart); end
        en = 1'b1;
        waitDrain(8, ok);
        total++; if (!ok) begin bad++; $display("FAIL burst_count: got %0d want 8", txLog.size()); end
        for (int i = 0; i < 8 && i < txLog.size(); i++) begin
            total++;
            if (txLog[i] !== 8'(i + 1)) begin bad++; $display("FAIL burst_order[%0d]: got %h want %h", i, txLog[i], 8'(i + 1)); end
        end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL burst_end_level: got %0d want 0", level); end
    endtask

    task automatic test_overflow();
        bit ok;
        applyReset();
        en = 1'b0;
        for (int i = 0; i < 9; i++) pushByte(8'($urandom_range(0, 255)), 1'b0);
        total++; if (level !== 4'd8) begin bad++; $display("FAIL ovf_level: got %0d want 8", level); end
        total++; if (overflow !== ovModel) begin bad++; $display("FAIL ovf_flag: got %b want %b", overflow, ovModel); end
        en = 1'b1;
        waitDrain(8, ok);
        repeat (40) @(posedge clk);
        #1;
        total++; if (txLog.size() != 8) begin bad++; $display("FAIL ovf_drained: got %0d want 8", txLog.size()); end
        for (int i = 0; i < 8 && i < txLog.size(); i++) begin
            total++;
            if (txLog[i] !== xform(expQ[i])) begin bad++; $display("FAIL ovf_data[%0d]: got %h want %h", i, txLog[i], xform(expQ[i])); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_rxerr();
        applyReset();
        en = 1'b1;
        pushByte(8'h55, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        total++; if (level !== 4'd0) begin bad++; $display("FAIL err_level: got %0d want 0", level); end
        total++; if (txLog.size() != 0 || txStart !== 1'b0) begin bad++; $display("FAIL err_notx: got %0d bytes want 0", txLog.size()); end
        total++; if (err_count !== 8'(errModel)) begin bad++; $display("FAIL err_one: got %0d want %0d", err_count, errModel); end
        for (int i = 0; i < 300; i++) pushByte(8'($urandom_range(0, 255)), 1'b1);
        total++; if (err_count !== 8'(errModel)) begin bad++; $display("FAIL err_sat: got %0d want %0d", err_count, errModel); end
    endtask

    task automatic test_random();
        bit ok;
        applyReset();
        en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            pushByte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(6, 12)) @(posedge clk);
            #1;
        end
        waitDrain(expQ.size(), ok);
        total++; if (!ok || txLog.size() != expQ.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", txLog.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < txLog.size(); i++) begin
            total++;
            if (txLog[i] !== xform(expQ[i])) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, txLog[i], xform(expQ[i])); end
        end
        total++; if (err_count !== 8'(errModel)) begin bad++; $display("FAIL rand_err: got %0d want %0d", err_count, errModel); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rand_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit ok;
        applyReset();
        respOn = 1'b0;
        en = 1'b1;
        pushByte(8'hC3, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (txStart) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_start: got 0 want 1"); end
        manBusy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!txStart) break;
            @(posedge clk); #1;
        end
        pushByte(8'h3C, 1'b0);
        total++; if (level !== 4'd1) begin bad++; $display("FAIL mid_queued: got %0d want 1", level); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (txStart !== 1'b0) begin bad++; $display("FAIL mid_txStart: got %b want 0", txStart); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", level); end
        reset = 1'b1;
        manBusy = 1'b0;
        expQ.delete();
        txLog.delete();
        errModel = 0;
        repeat (2) @(posedge clk);
        #1;
        respOn = 1'b1;
        pushByte(8'h5A, 1'b0);
        waitDrain(1, ok);
        total++; if (!ok || txLog[0] !== 8'h5A) begin bad++; $display("FAIL mid_echo: got %0d bytes want 5a", txLog.size()); end
    endtask

    task automatic test_upcase();
        bit ok;
        logic [7:0] want [3];
`ifdef UART_ECHO_UPCASE_EN
        want = '{8'h41, 8'h7B, 8'h41};
`else
        want = '{8'h61, 8'h7B, 8'h41};
`endif
        applyReset();
        en = 1'b1;
        pushByte(8'h61, 1'b0);
        pushByte(8'h7B, 1'b0);
        pushByte(8'h41, 1'b0);
        waitDrain(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL case_count: got %0d want 3", txLog.size()); end
        for (int i = 0; i < 3 && i < txLog.size(); i++) begin
            total++;
            if (txLog[i] !== want[i]) begin bad++; $display("FAIL case_data[%0d]: got %h want %h", i, txLog[i], want[i]); end
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
        manBusy = 1'b0; respOn = 1'b0; errModel = 0; ovModel = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_rxerr();
        test_random();
        test_reset_mid();
        test_upcase();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
